// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: bundles the burst control, upstream FWFT FIFO and
// downstream valid/ready stream. master = reader side, slave = environment.
interface fifo_burst_reader_if #(
  parameter int WIDTH  = 8,
  parameter int LENWID = 4
);
  logic              start;
  logic [LENWID-1:0] len;
  logic              busy;
  logic              done;
  logic              err;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_data;
  logic              fifo_pop;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;

  modport master (
    input  start, len, fifo_empty, fifo_data, out_ready,
    output busy, done, err, fifo_pop,
    output out_valid, out_data, out_last
  );

  modport slave (
    output start, len, fifo_empty, fifo_data, out_ready,
    input  busy, done, err, fifo_pop,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops len words from a FWFT FIFO into a registered
// valid/ready output stage, flags the last word and pulses done.
// Ports: clk, rst (async active-low), bus (fifo_burst_reader_if.master):
//   start/len/busy/done/err control, fifo_empty/fifo_data/fifo_pop
//   upstream, out_valid/out_ready/out_data/out_last downstream.
// Option: define READER_TIMEOUT_EN to abort a burst (err pulse) after
//   TIMEOUT consecutive empty-FIFO stall cycles; otherwise err is 0.
module fifo_burst_reader #(
  parameter int WIDTH   = 8,
  parameter int LENWID  = 4,
  parameter int TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  fifo_burst_reader_if.master bus
);
  typedef enum logic {IDLE, READ} state_e;

  state_e            state_q, state_d;
  logic [LENWID-1:0] rem_q, rem_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              done_q, done_d;
  logic              pop;
  logic              hs;

`ifdef READER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
  logic          stall;
`endif

  assign hs  = out_valid_q & bus.out_ready;
  assign pop = (state_q == READ) & ~bus.fifo_empty
             & (rem_q != '0)
             & (~out_valid_q | bus.out_ready);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = bus.len;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (hs & out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop refills the output stage in the same edge a handshake drains it.
    if (pop) begin
      out_data_d  = bus.fifo_data;
      out_valid_d = 1'b1;
      out_last_d  = (rem_q == LENWID'(1));
      rem_d       = rem_q - LENWID'(1);
    end else if (hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

`ifdef READER_TIMEOUT_EN
    stall_d = '0;
    err_d   = 1'b0;
    stall   = (state_q == READ) & (rem_q != '0)
            & bus.fifo_empty;
    if (stall) begin
      stall_d = stall_q + SW'(1);
      // Abort on the TIMEOUT-th stall cycle; a pending word stays put.
      if (stall_q == SW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        rem_d   = '0;
        stall_d = '0;
        err_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

`ifdef READER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy      = (state_q == READ);
  assign bus.done      = done_q;
  assign bus.fifo_pop  = pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
endmodule
